// File: rtl/onchip_ram_arbiter_pkg.sv
// Shared types and widths for the two-requester on-chip RAM arbiter.
package onchip_ram_arb_pkg;

  localparam int unsigned AW   = 14;
  localparam int unsigned DW   = 32;
  localparam int unsigned BEW  = 4;
  localparam int unsigned ERRW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [BEW-1:0] be;
    logic [DW-1:0]  wdata;
    logic           wr;
  } req_t;

endpackage

// File: rtl/onchip_ram_arbiter_if.sv
// Requester, RAM-port and status signals of the on-chip RAM arbiter.
interface onchip_ram_arbiter_if;
  import onchip_ram_arb_pkg::*;

  logic [AW-1:0]   m0_address,    m1_address;
  logic [BEW-1:0]  m0_byteenable, m1_byteenable;
  logic            m0_read,       m1_read;
  logic            m0_write,      m1_write;
  logic [DW-1:0]   m0_writedata,  m1_writedata;
  logic            m0_waitrequest,   m1_waitrequest;
  logic            m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0]   m0_readdata,      m1_readdata;

  logic [AW-1:0]   mem_address;
  logic [BEW-1:0]  mem_byteenable;
  logic [DW-1:0]   mem_writedata;
  logic            mem_chipselect;
  logic            mem_write;
  logic            mem_clken;
  logic [DW-1:0]   mem_readdata;

  logic            hold_off;
  logic [ERRW-1:0] err_count;

  // Arbiter side
  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m0_waitrequest, m0_readdatavalid, m0_readdata,
    output m1_waitrequest, m1_readdatavalid, m1_readdata,
    output mem_address, mem_byteenable, mem_writedata,
    output mem_chipselect, mem_write, mem_clken,
    input  mem_readdata, hold_off,
    output err_count
  );

  // Requester / environment side
  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m0_waitrequest, m0_readdatavalid, m0_readdata,
    input  m1_waitrequest, m1_readdatavalid, m1_readdata,
    input  mem_address, mem_byteenable, mem_writedata,
    input  mem_chipselect, mem_write, mem_clken,
    output mem_readdata, hold_off,
    input  err_count
  );

endinterface

// File: rtl/onchip_ram_arbiter.sv
// Two-requester arbiter onto a single-port on-chip RAM with bounded bursts,
// quiesce control and out-of-range access counting.
module onchip_ram_arbiter
  import onchip_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 12288,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  onchip_ram_arbiter_if.slave  bus
);

  localparam int unsigned BCW = $clog2(MAX_BURST + 1);

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [BCW-1:0]  burst_cnt_q, burst_cnt_d;
  logic [1:0]      rd_pend_q, rd_pend_d;
  logic            rd_oor_q, rd_oor_d;
  logic [ERRW-1:0] err_count_q, err_count_d;

  req_t       req_p [2];
  req_t       acc_p;
  logic [1:0] req, grant, accept;
  logic       acc_any, acc_sel, acc_oor;

  always_comb begin
    req_p[0] = '{addr: bus.m0_address, be: bus.m0_byteenable,
                 wdata: bus.m0_writedata, wr: bus.m0_write};
    req_p[1] = '{addr: bus.m1_address, be: bus.m1_byteenable,
                 wdata: bus.m1_writedata, wr: bus.m1_write};
    req      = {bus.m1_read | bus.m1_write, bus.m0_read | bus.m0_write};
  end

  // Grant: owner keeps the port until its burst quota runs out with the other side waiting
  always_comb begin
    grant = 2'b00;
    if (reset_n && !bus.hold_off) begin
      unique case (state_q)
        ST_OWN0: begin
          if (req[0] && (!req[1] || burst_cnt_q < BCW'(MAX_BURST))) grant = 2'b01;
          else if (req[1])                                         grant = 2'b10;
        end
        ST_OWN1: begin
          if (req[1] && (!req[0] || burst_cnt_q < BCW'(MAX_BURST))) grant = 2'b10;
          else if (req[0])                                         grant = 2'b01;
        end
        default: begin
          if (&req) grant = last_grant_q ? 2'b01 : 2'b10;
          else      grant = req;
        end
      endcase
    end
  end

  always_comb begin
    accept  = req & grant;
    acc_any = |accept;
    acc_sel = accept[1];
    acc_p   = acc_sel ? req_p[1] : req_p[0];
    acc_oor = 32'(acc_p.addr) >= NUM_WORDS;
  end

  // Next state; no accepted access (idle or quiesced) returns to IDLE
  always_comb begin
    state_d      = ST_IDLE;
    last_grant_d = last_grant_q;
    burst_cnt_d  = '0;
    rd_pend_d    = 2'b00;
    rd_oor_d     = 1'b0;
    err_count_d  = err_count_q;
    if (acc_any) begin
      state_d      = acc_sel ? ST_OWN1 : ST_OWN0;
      last_grant_d = acc_sel;
      if (state_d != state_q)                    burst_cnt_d = BCW'(1);
      else if (burst_cnt_q < BCW'(MAX_BURST))    burst_cnt_d = burst_cnt_q + BCW'(1);
      else                                       burst_cnt_d = burst_cnt_q;
      rd_pend_d = acc_p.wr ? 2'b00 : accept;
      rd_oor_d  = ~acc_p.wr & acc_oor;
      if (acc_oor && err_count_q != {ERRW{1'b1}}) err_count_d = err_count_q + ERRW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      burst_cnt_q  <= '0;
      rd_pend_q    <= 2'b00;
      rd_oor_q     <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_oor_q     <= rd_oor_d;
      err_count_q  <= err_count_d;
    end
  end

  // RAM port and requester responses; RAM read data is unregistered so passes straight through
  always_comb begin
    bus.m0_waitrequest   = req[0] & ~grant[0];
    bus.m1_waitrequest   = req[1] & ~grant[1];
    bus.m0_readdatavalid = rd_pend_q[0];
    bus.m1_readdatavalid = rd_pend_q[1];
    bus.m0_readdata      = (rd_pend_q[0] && !rd_oor_q) ? bus.mem_readdata : '0;
    bus.m1_readdata      = (rd_pend_q[1] && !rd_oor_q) ? bus.mem_readdata : '0;
    bus.mem_address      = acc_p.addr;
    bus.mem_byteenable   = acc_p.be;
    bus.mem_writedata    = acc_p.wdata;
    bus.mem_chipselect   = acc_any;
    bus.mem_write        = acc_any & acc_p.wr & ~acc_oor;
    bus.mem_clken        = ~bus.hold_off | (|rd_pend_q);
    bus.err_count        = err_count_q;
  end

endmodule
